dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory target for the single-cycle core's DM port: word RAM with byte-lane writes plus a small MMIO page.
//  Serves the core's DM address, write data, write-enable, read-enable and LSU byte-select outputs.
//  Returns the read word in the same cycle and commits writes on the clock edge.
//  MMIO page holds GPIO_OUT, a 64-bit cycle counter with a coherent hi/lo snapshot, and a sticky error status.
// PARAMETERS
//  DEPTH_WORDS  1024           RAM depth in 32-bit words (power of 2)
//  RAM_BASE     32'h0000_0000  byte base of RAM region, aligned to 4*DEPTH_WORDS
//  MMIO_BASE    32'h1000_0000  byte base of 16-byte MMIO page
// PORTS
//  i_clk      in   1   clock, rising edge
//  i_rst      in   1   reset, asynchronous, active-high
//  i_addr     in   32  byte address of the access
//  i_wd       in   32  store data, already lane-aligned to i_be
//  i_be       in   4   byte enables (LSU range select)
//  i_wen      in   1   store request this cycle
//  i_ren      in   1   load request this cycle
//  o_rd       out  32  read word, combinational from i_addr
//  o_err      out  1   registered one-cycle pulse: previous access faulted
//  o_gpio     out  32  GPIO_OUT register
// BEHAVIOUR
//  Reset (async, high): o_gpio=0, cycle=0, snapshot=0, sticky=0, o_err=0. RAM contents are not reset.
//  A store presented in a cycle where i_rst is asserted is discarded.
//  Decode:
//    RAM   if RAM_BASE <= addr < RAM_BASE + 4*DEPTH_WORDS; word index = addr[log2(DEPTH)+1:2].
//    MMIO  if addr[31:4] == MMIO_BASE[31:4].
//    Otherwise unmapped. Address bits [1:0] are ignored for decode.
//  MMIO offsets:
//    0x0 GPIO_OUT  RW
//    0x4 CYC_LO    RO
//    0x8 CYC_HI    RO
//    0xC STATUS    bit0 = sticky error, write-1-to-clear; other bits read 0
//  Read (i_ren=1, i_wen=0):
//    o_rd = full 32-bit word at the word address; the core LSU extracts and extends.
//    Unmapped read: o_rd=0 and fault.
//    With i_ren=0: o_rd=0.
//  Write (i_wen=1): at posedge, only lanes with i_be[k]=1 take i_wd[8k+7:8k]; other lanes unchanged.
//  Legal i_be values: 0001 0010 0100 1000 0011 1100 1111.
//    Any other i_be with i_wen: write suppressed, fault.
//  Faults (write suppressed in every case):
//    - unmapped write
//    - write to CYC_LO/CYC_HI
//    - i_wen && i_ren in the same cycle; read still served
//  Fault timing: o_err=1 in the following cycle only; sticky<=1 at the same edge.
//  Sticky error: W1C of STATUS bit0 clears it. If a fault and a W1C land in the same cycle, set wins.
//  Cycle counter:
//    - 64-bit, +1 every non-reset cycle, wraps 2^64-1 -> 0.
//  Snapshot:
//    - A read of CYC_LO returns cycle[31:0] and, at that edge, latches cycle[63:32] into the snapshot.
//    - A read of CYC_HI returns the snapshot, not the live value.
//    - Loading LO then HI therefore gives a coherent 64-bit value across a 32-bit carry.
//  Sub-word MMIO writes are legal; i_be lanes apply to GPIO_OUT, and to STATUS bit0 via lane 0.
//  No stalls: every access completes in its own cycle; back-to-back accesses on every cycle are supported.
// STRUCTURE
//  Shared package dm_pkg:
//    MMIO offset localparams (OFF_GPIO, OFF_CYC_LO, OFF_CYC_HI, OFF_STATUS)
//    legal byte-enable list and an is_legal_be() function
//    reuse of the existing addr_t/data_t typedefs
//  Sub-module dm_cycle_counter: 64-bit counter + hi snapshot; ports i_clk, i_rst, i_snap, o_lo, o_hi_snap.
//  Top level: decode, lane-merge write logic, RAM array, GPIO/status registers, fault pipeline register.
// TESTING
//  1. Reset, then SW 0xDEADBEEF to 0x40 (be=1111), then LW 0x40.
//     -> o_rd=0xDEADBEEF combinationally; o_err stays 0.
//  2. SB 0x0000_5500 be=0010 to word 0x40, then read it back.
//     -> 0xDEAD55EF; a further SH 0x1234_0000 be=1100 -> 0x123455EF.
//  3. Write with be=0101 to 0x80, and a separate write to 0x2000_0000 (unmapped).
//     -> RAM unchanged; o_err pulses one cycle after each; STATUS reads 1.
//     -> W1C 0x1 to STATUS; read back gives 0.
//  4. Force the counter to 0x0000_0000_FFFF_FFFF; read CYC_LO, then CYC_HI on the next cycle.
//     -> LO=0xFFFF_FFFF, HI=0 (snapshot), even though the live hi is now 1.
//  5. Assert i_wen and i_ren together on GPIO with wd=0xA5.
//     -> o_gpio unchanged, old value read, o_err pulses.
//  6. Store to GPIO 0x1 and assert i_rst in the same cycle.
//     -> o_gpio=0, o_err=0 immediately (async); after release the counter restarts from 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types, MMIO register map and byte-enable helpers for the data-memory responder.
package dm_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  localparam logic [3:0] OFF_GPIO   = 4'h0;
  localparam logic [3:0] OFF_CYC_LO = 4'h4;
  localparam logic [3:0] OFF_CYC_HI = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int unsigned NUM_LEGAL_BE = 7;
  localparam logic [NUM_LEGAL_BE-1:0][3:0] LEGAL_BE = {
    4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  // Only byte, aligned half and full-word lane patterns come out of the LSU.
  function automatic logic is_legal_be(input logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < NUM_LEGAL_BE; i++) begin
      if (LEGAL_BE[i] == be) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic data_t lane_merge(input data_t old, input data_t wd, input logic [3:0] be);
    data_t res;
    res = old;
    for (int unsigned k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = wd[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_cycle_counter.sv
// Free-running 64-bit cycle counter with a high-word snapshot taken when the low word is read.
module dm_cycle_counter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_snap,
  output logic [31:0] o_lo,
  output logic [31:0] o_hi_snap
);

  logic [63:0] cyc_q;
  logic [31:0] snap_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cyc_q  <= '0;
      snap_q <= '0;
    end else begin
      cyc_q <= cyc_q + 64'd1;
      // Capture the pre-increment high word so LO-then-HI reads stay coherent across a carry.
      if (i_snap) snap_q <= cyc_q[63:32];
    end
  end

  assign o_lo      = cyc_q[31:0];
  assign o_hi_snap = snap_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core's DM port: byte-lane word RAM plus a 16-byte MMIO page.
module dmem_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter addr_t       RAM_BASE    = 32'h0000_0000,
  parameter addr_t       MMIO_BASE   = 32'h1000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  input  logic [3:0]  i_be,
  input  logic        i_wen,
  input  logic        i_ren,
  output logic [31:0] o_rd,
  output logic        o_err,
  output logic [31:0] o_gpio
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  data_t          mem [DEPTH_WORDS];
  logic [AW-1:0]  widx;
  logic [3:0]     off;
  logic           is_ram, is_mmio, mapped;
  logic           wr_cyc, wr_fault, rd_fault, fault, wr_ok, ram_we, snap;
  logic [31:0]    cyc_lo, cyc_hi_snap;
  logic [31:0]    gpio_q;
  logic           sticky_q, err_q;
  logic           unused_addr_lo;

  assign unused_addr_lo = ^i_addr[1:0];

  // RAM_BASE is aligned to the region size, so an upper-bit match is the range check.
  assign is_ram  = (i_addr[31:AW+2] == RAM_BASE[31:AW+2]);
  assign is_mmio = (i_addr[31:4] == MMIO_BASE[31:4]);
  assign mapped  = is_ram | is_mmio;
  assign widx    = i_addr[AW+1:2];
  assign off     = {i_addr[3:2], 2'b00};

  assign wr_cyc   = is_mmio && ((off == OFF_CYC_LO) || (off == OFF_CYC_HI));
  assign wr_fault = i_wen && (!is_legal_be(i_be) || !mapped || wr_cyc || i_ren);
  assign rd_fault = i_ren && !mapped;
  assign fault    = wr_fault | rd_fault;
  assign wr_ok    = i_wen && !fault && !i_rst;
  assign ram_we   = wr_ok && is_ram;
  assign snap     = i_ren && is_mmio && (off == OFF_CYC_LO);

  dm_cycle_counter u_cyc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_snap    (snap),
    .o_lo      (cyc_lo),
    .o_hi_snap (cyc_hi_snap)
  );

  always_ff @(posedge i_clk) begin
    if (ram_we) mem[widx] <= lane_merge(mem[widx], i_wd, i_be);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gpio_q   <= '0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= fault;
      if (wr_ok && is_mmio && (off == OFF_GPIO)) gpio_q <= lane_merge(gpio_q, i_wd, i_be);
      // A fault in the same cycle as a W1C leaves the error set.
      if (fault) begin
        sticky_q <= 1'b1;
      end else if (wr_ok && is_mmio && (off == OFF_STATUS) && i_be[0] && i_wd[0]) begin
        sticky_q <= 1'b0;
      end
    end
  end

  always_comb begin
    o_rd = '0;
    if (i_ren) begin
      if (is_ram) begin
        o_rd = mem[widx];
      end else if (is_mmio) begin
        case (off)
          OFF_GPIO:   o_rd = gpio_q;
          OFF_CYC_LO: o_rd = cyc_lo;
          OFF_CYC_HI: o_rd = cyc_hi_snap;
          OFF_STATUS: o_rd = {31'b0, sticky_q};
          default:    o_rd = '0;
        endcase
      end
    end
  end

  assign o_err  = err_q;
  assign o_gpio = gpio_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder against a plain behavioural memory/MMIO model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] MMIO  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wd, rd, gpio;
  logic [3:0]  be;
  logic        wen, ren, err;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .RAM_BASE    (32'h0000_0000),
    .MMIO_BASE   (MMIO)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_addr (addr),
    .i_wd   (wd),
    .i_be   (be),
    .i_wen  (wen),
    .i_ren  (ren),
    .o_rd   (rd),
    .o_err  (err),
    .o_gpio (gpio)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [31:0] gpio;
    logic        chk_rd;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          seq = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_gpio;
  logic [63:0] m_cyc;
  logic [31:0] m_snap;
  bit          m_sticky;
  bit          m_prev_fault;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // One access per cycle: push the expected view of this cycle, then advance the model.
  task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     input bit w, input bit r);
    exp_t e;
    bit   ram_hit, mmio_hit, legal, fault;
    int   wi, reg_i;
    ram_hit  = a < 4 * DEPTH;
    mmio_hit = (a >> 4) == (MMIO >> 4);
    wi       = int'(a >> 2);
    reg_i    = int'((a >> 2) & 32'd3);
    legal    = b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    e.rd     = '0;
    e.chk_rd = 1'b1;
    if (r) begin
      if (ram_hit) begin
        if (m_ram.exists(wi)) e.rd = m_ram[wi];
        else e.chk_rd = 1'b0;
      end else if (mmio_hit) begin
        case (reg_i)
          0:       e.rd = m_gpio;
          1:       e.rd = m_cyc[31:0];
          2:       e.rd = m_snap;
          default: e.rd = {31'b0, m_sticky};
        endcase
      end
    end
    fault = (r && !ram_hit && !mmio_hit) ||
            (w && (!legal || (!ram_hit && !mmio_hit) || (mmio_hit && (reg_i == 1 || reg_i == 2))
                   || r));
    e.err  = m_prev_fault;
    e.gpio = m_gpio;
    sbq.push_back(e);
    addr = a; wd = d; be = b; wen = w; ren = r;
    if (r && mmio_hit && reg_i == 1) m_snap = m_cyc[63:32];
    if (w && !fault) begin
      if (ram_hit) begin
        if (m_ram.exists(wi)) m_ram[wi] = merge(m_ram[wi], d, b);
        else if (b == 4'hF) m_ram[wi] = d;
      end else if (reg_i == 0) begin
        m_gpio = merge(m_gpio, d, b);
      end else if (reg_i == 3 && b[0] && d[0]) begin
        m_sticky = 1'b0;
      end
    end
    if (fault) m_sticky = 1'b1;
    m_prev_fault = fault;
    @(posedge clk);
    #1;
    m_cyc++;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      seq++;
      if (mon_e.chk_rd) check($sformatf("rd #%0d", seq), rd, mon_e.rd);
      check($sformatf("err #%0d", seq), {31'b0, err}, {31'b0, mon_e.err});
      check($sformatf("gpio #%0d", seq), gpio, mon_e.gpio);
    end
  end

  initial begin
    logic [31:0] ra;
    logic [3:0]  rb;
    int          sel;
    rst = 1'b1; addr = '0; wd = '0; be = '0; wen = 1'b0; ren = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset gpio", gpio, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    check("reset rd idle", rd, 32'h0);
    m_gpio = '0; m_cyc = '0; m_snap = '0; m_sticky = 1'b0; m_prev_fault = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) acc(32'(i * 4), $urandom, 4'hF, 1'b1, 1'b0);
    acc(32'((DEPTH - 1) * 4), $urandom, 4'hF, 1'b1, 1'b0);
    acc(32'h80, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0);

    // Full-word store then load
    acc(32'h40, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
    acc(32'h40, 32'h0, 4'h0, 1'b0, 1'b1);
    // Byte and half stores
    acc(32'h40, 32'h0000_5500, 4'b0010, 1'b1, 1'b0);
    acc(32'h41, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(32'h40, 32'h1234_0000, 4'b1100, 1'b1, 1'b0);
    acc(32'h40, 32'h0, 4'h0, 1'b0, 1'b1);
    // Illegal byte enable and unmapped store, then status W1C
    acc(32'h80, 32'hFFFF_FFFF, 4'b0101, 1'b1, 1'b0);
    acc(32'h80, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(32'h2000_0000, 32'h1111_1111, 4'hF, 1'b1, 1'b0);
    acc(MMIO + 32'hC, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(MMIO + 32'hC, 32'h1, 4'b0001, 1'b1, 1'b0);
    acc(MMIO + 32'hC, 32'h0, 4'h0, 1'b0, 1'b1);
    // Counter carry: snapshot must hold the pre-carry high word
    dut.u_cyc.cyc_q = 64'h0000_0000_FFFF_FFFF;
    m_cyc = 64'h0000_0000_FFFF_FFFF;
    acc(MMIO + 32'h4, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(MMIO + 32'h8, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(MMIO + 32'h4, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(MMIO + 32'h8, 32'h0, 4'h0, 1'b0, 1'b1);
    // Simultaneous read and write on GPIO
    acc(MMIO, 32'h0000_003C, 4'hF, 1'b1, 1'b0);
    acc(MMIO, 32'h0000_00A5, 4'hF, 1'b1, 1'b1);
    acc(MMIO, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 4)      ra = 32'($urandom_range(0, 63));
      else if (sel == 5) ra = 32'((DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      else if (sel <= 7) ra = MMIO + 32'($urandom_range(0, 15));
      else if (sel == 8) ra = 32'h2000_0000 + 32'($urandom_range(0, 255));
      else               ra = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 6))
          0: rb = 4'b0001; 1: rb = 4'b0010; 2: rb = 4'b0100; 3: rb = 4'b1000;
          4: rb = 4'b0011; 5: rb = 4'b1100; default: rb = 4'b1111;
        endcase
      end else begin
        rb = 4'($urandom_range(0, 15));
      end
      sel = int'($urandom_range(0, 7));
      acc(ra, $urandom, rb, sel >= 4, (sel >= 1 && sel <= 3) || sel == 7);
    end

    // Async reset during a GPIO store right after a fault
    acc(MMIO, 32'h0000_0077, 4'hF, 1'b1, 1'b0);
    acc(32'h2000_0000, 32'h0, 4'hF, 1'b1, 1'b0);
    addr = MMIO; wd = 32'h1; be = 4'hF; wen = 1'b1; ren = 1'b0;
    rst = 1'b1;
    #1;
    check("async rst gpio", gpio, 32'h0);
    check("async rst err", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; wen = 1'b0;
    m_gpio = '0; m_cyc = '0; m_snap = '0; m_sticky = 1'b0; m_prev_fault = 1'b0;
    acc(MMIO + 32'h4, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(MMIO, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(MMIO + 32'h4, 32'h0, 4'h0, 1'b0, 1'b1);
    acc(MMIO + 32'hC, 32'h0, 4'h0, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    check("scoreboard drained", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
